// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module   : multicycle_controller_if
// Purpose  : Shared instruction/data memory handshake between sequencer and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : RV32I multi-cycle sequencer (fetch/decode/execute/mem/writeback).
//            CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOPs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int RESET_TRAP_CLEAR = 1
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  multicycle_controller_if.master      mem,
  input  wire logic [31:0]             instruction,
  input  wire logic                    branch_taken,
  output logic [2:0]                   imm_op,
  output logic                         ir_we,
  output logic                         pc_we,
  output logic [1:0]                   pc_src,
  output logic [1:0]                   alu_src_a,
  output logic                         alu_src_b,
  output logic [1:0]                   alu_op,
  output logic [1:0]                   result_src,
  output logic                         reg_we,
  output logic                         retire,
  output logic                         illegal_instr,
  output logic [2:0]                   state
);

  localparam logic [2:0] FETCH     = 3'b000;
  localparam logic [2:0] DECODE    = 3'b001;
  localparam logic [2:0] EXECUTE   = 3'b010;
  localparam logic [2:0] MEM       = 3'b011;
  localparam logic [2:0] WRITEBACK = 3'b100;
  localparam logic [2:0] TRAP      = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [6:0] w_opcode;
  logic       w_known;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic [1:0] w_alu_src_a;
  logic       w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_result_src;
  logic       w_reg_we;
  logic       w_retire;
  logic       w_unused_trap_clear;

  assign w_opcode = instruction[6:0];
  assign w_unused_trap_clear = (RESET_TRAP_CLEAR != 0);

  always_comb begin
    imm_op  = IMM_I;
    w_known = 1'b1;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_OP: imm_op = IMM_I;
      OP_STORE:                        imm_op = IMM_S;
      OP_BRANCH:                       imm_op = IMM_B;
      OP_LUI, OP_AUIPC:                imm_op = IMM_U;
      OP_JAL:                          imm_op = IMM_J;
      default: begin
        imm_op  = IMM_I;
        w_known = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 1'b0;
    w_alu_op     = 2'b00;
    w_result_src = 2'b00;
    w_reg_we     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_req = 1'b1;
        if (mem.mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = DECODE;
        end
      end
      DECODE: begin
        if (w_known) begin
          w_next = EXECUTE;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_next = TRAP;
`else
          // PC already advanced in FETCH, so retiring here makes it a NOP
          w_retire = 1'b1;
          w_next   = FETCH;
`endif
        end
      end
      EXECUTE: begin
        w_next = WRITEBACK;
        case (w_opcode)
          OP_LOAD, OP_STORE: begin
            w_alu_src_b = 1'b1;
            w_next      = MEM;
          end
          OP_IMM: begin
            w_alu_src_b = 1'b1;
            w_alu_op    = 2'b10;
          end
          OP_OP: begin
            w_alu_op = 2'b01;
          end
          OP_LUI: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 1'b1;
          end
          OP_AUIPC: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 1'b1;
          end
          OP_JAL: begin
            w_pc_we  = 1'b1;
            w_pc_src = 2'b01;
          end
          OP_JALR: begin
            w_alu_src_b = 1'b1;
            w_pc_we     = 1'b1;
            w_pc_src    = 2'b10;
          end
          OP_BRANCH: begin
            w_pc_we  = branch_taken;
            w_pc_src = 2'b01;
            w_retire = 1'b1;
            w_next   = FETCH;
          end
          default: w_next = FETCH;
        endcase
      end
      MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (w_opcode == OP_STORE);
        if (mem.mem_ready) begin
          if (w_opcode == OP_STORE) begin
            w_retire = 1'b1;
            w_next   = FETCH;
          end else begin
            w_next = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        w_reg_we = 1'b1;
        w_retire = 1'b1;
        if (w_opcode == OP_LOAD) begin
          w_result_src = 2'b01;
        end else if (w_opcode == OP_JAL || w_opcode == OP_JALR) begin
          w_result_src = 2'b10;
        end
        w_next = FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP: w_next = TRAP;
`endif
      default: w_next = FETCH;
    endcase
  end

  // Reset blanks every strobe and select immediately, not just on the next edge
  assign mem.mem_req = w_mem_req & ~rst;
  assign mem.mem_we  = w_mem_we & ~rst;
  assign ir_we       = w_ir_we & ~rst;
  assign pc_we       = w_pc_we & ~rst;
  assign reg_we      = w_reg_we & ~rst;
  assign retire      = w_retire & ~rst;
  assign pc_src      = rst ? 2'b00 : w_pc_src;
  assign alu_src_a   = rst ? 2'b00 : w_alu_src_a;
  assign alu_src_b   = w_alu_src_b & ~rst;
  assign alu_op      = rst ? 2'b00 : w_alu_op;
  assign result_src  = rst ? 2'b00 : w_result_src;
  assign state       = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  // With RESET_TRAP_CLEAR=0 the flag relies on the register's power-up value
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_unused_trap_clear) begin
        r_illegal <= 1'b0;
      end
    end else if (r_state == DECODE && !w_known) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_instr = r_illegal;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. It generates every datapath strobe and mux select, including the `imm_op` code consumed by the immediate generator. It sits between the shared instruction/data memory port, the instruction register and the register-file/ALU datapath.

## Interface
Parameters:
- `RESET_TRAP_CLEAR`, default 1. 1 means `rst` clears the sticky `illegal_instr` flag; 0 means only power-on reset clears it (bench uses 1).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `instruction`  in  32  instruction register contents, stable from DECODE onward.
- `mem_ready`  in  1  memory handshake completion.
- `branch_taken`  in  1  branch comparator result for the current funct3.
- `imm_op`  out  3  immediate format code:
  - I=000, S=001, B=010, U=011, J=100.
  - R-type and illegal encodings give 000.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write (store).
- `ir_we`  out  1  instruction register and old_pc capture.
- `pc_we`  out  1  PC write.
- `pc_src`  out  2  00 PC+4; 01 old_pc+imm; 10 ALU result with bit0 cleared.
- `alu_src_a`  out  2  00 rs1; 01 old_pc; 10 zero.
- `alu_src_b`  out  1  0 rs2; 1 imm.
- `alu_op`  out  2  00 ADD; 01 R-type funct decode; 10 I-type funct decode.
- `result_src`  out  2  00 ALU; 01 memory read data; 10 link (PC+4).
- `reg_we`  out  1  register-file write.
- `retire`  out  1  one-cycle pulse on an instruction's final cycle.
- `illegal_instr`  out  1  sticky illegal-opcode flag.
- `state`  out  3  current state, for debug.

## Operation
- States:
  - FETCH=000, DECODE=001, EXECUTE=010, MEM=011, WRITEBACK=100, TRAP=101.
  - Transitions are taken on a `clk` edge.
- FETCH:
  - `mem_req`=1 and holds while `mem_ready`=0.
  - In the cycle `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=00, then go to DECODE.
- DECODE:
  - Decode `instruction[6:0]` and go to EXECUTE.
  - An unknown opcode goes to TRAP or is skipped (see Configuration).
- EXECUTE, per opcode:
  - LOAD 0000011 / STORE 0100011: a=rs1, b=imm, ADD; go to MEM.
  - OP-IMM 0010011: a=rs1, b=imm, `alu_op`=10; go to WRITEBACK.
  - OP 0110011: a=rs1, b=rs2, `alu_op`=01; go to WRITEBACK.
  - LUI 0110111: a=zero, b=imm, ADD. AUIPC 0010111: a=old_pc, b=imm, ADD. Both go to WRITEBACK.
  - JAL 1101111: `pc_we`=1, `pc_src`=01; go to WRITEBACK.
  - JALR 1100111: a=rs1, b=imm, ADD, `pc_we`=1, `pc_src`=10; go to WRITEBACK.
  - BRANCH 1100011: `pc_we`=`branch_taken`, `pc_src`=01, `retire`=1; go to FETCH.
- MEM:
  - `mem_req`=1; `mem_we`=1 for STORE only. Holds while `mem_ready`=0.
  - On `mem_ready`: LOAD goes to WRITEBACK; STORE pulses `retire` and goes to FETCH.
- WRITEBACK:
  - `reg_we`=1 and `retire`=1, then go to FETCH.
  - `result_src`: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- `imm_op` is a combinational function of `instruction[6:0]` in every state.
- `mem_ready` is ignored outside FETCH and MEM.

## Timing
- Outputs are Moore-style, decoded from the state register and `instruction`. No output depends on `mem_ready` except `ir_we`, `pc_we`, `retire` and the state advance in FETCH/MEM.
- Cycle counts with `mem_ready` tied high:
  - BRANCH: 3 cycles.
  - STORE, ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Reset:
  - `rst`=1 forces every strobe (`mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we`, `retire`) to 0 combinationally.
  - All selects read 0.
  - The state becomes FETCH on the next edge.
- Reset in the middle of an instruction abandons it: no `reg_we` or `pc_we` is issued. `illegal_instr` clears per `RESET_TRAP_CLEAR`.
- The first `mem_req` appears in the first cycle after `rst` falls.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to TRAP.
  - `illegal_instr` rises the next cycle and stays high.
  - TRAP has all strobes at 0 and is left only by `rst`. `retire` is never pulsed.
- Undefined:
  - An unknown opcode in DECODE pulses `retire` and returns to FETCH, so it executes as a NOP.
  - The PC was already incremented in FETCH.
  - `illegal_instr` is tied to 0 and TRAP is unreachable.

## Test plan
- `addi x1,x0,5` (0x00500093), `mem_ready`=1:
  - States FETCH→DECODE→EXECUTE→WRITEBACK.
  - `imm_op`=000, `alu_src_b`=1, `alu_op`=10.
  - `reg_we`, `result_src`=00 and `retire` all in cycle 4.
- `sw x1,8(x0)` (0x00102423):
  - `imm_op`=001.
  - In MEM: `mem_req`=1, `mem_we`=1, `retire`=1.
  - `reg_we` never asserted; 4 cycles total.
- `beq x0,x0,8` (0x00000463):
  - With `branch_taken`=1: `imm_op`=010, and EXECUTE has `pc_we`=1, `pc_src`=01, `retire`=1; 3 cycles.
  - Repeat with `branch_taken`=0: `pc_we`=0 in EXECUTE.
- `lw x2,0(x0)` (0x00002103), with `mem_ready` low for 3 MEM cycles:
  - MEM holds for 4 cycles.
  - WRITEBACK has `result_src`=01; 8 cycles total.
- 0xFFFFFFFF with the macro defined:
  - TRAP reached; `illegal_instr`=1 persists for 10 cycles until `rst`.
  - Without the macro: `retire` pulses in DECODE, then FETCH.
- `rst` pulsed during MEM of a load:
  - All strobes are 0 during `rst`.
  - `state`=FETCH on the next edge.
  - No `reg_we` is issued for the aborted load.
